match_tally: RTL

Statistics stage placed directly downstream of the `counting` sequence detector; it consumes that block's per-cycle `ans` match flag. It tallies detected matches in a saturating counter and measures the spacing between consecutive matches (last gap, minimum gap). It also offers a request/acknowledge snapshot port so software-facing logic can read a coherent, frozen copy of the statistics while counting continues.

---
 rtl/match_tally_pkg.sv | 25 ++
 rtl/sat_counter.sv | 48 ++++
 rtl/match_tally.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/match_tally_pkg.sv
// match_tally_pkg
// Shared types and constants for the match_tally statistics stage.
//   - stats_state_e : match-tracking FSM (IDLE until the first match, then ARMED)
//   - snap_state_e  : snapshot handshake FSM (S_IDLE, S_HOLD)
//   - DEF_CNT_W / DEF_GAP_W : default counter widths
//   - CNT_MAX / GAP_MAX     : all-ones saturation values for the default widths
package match_tally_pkg;

    localparam int DEF_CNT_W = 8;
    localparam int DEF_GAP_W = 8;

    localparam logic [DEF_CNT_W-1:0] CNT_MAX = '1;
    localparam logic [DEF_GAP_W-1:0] GAP_MAX = '1;

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } stats_state_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } snap_state_e;

endpackage

// File: rtl/sat_counter.sv
// sat_counter
// Saturating up-counter with synchronous clear.
// Ports:
//   clk_i   : clock
//   rst_i   : synchronous active-high reset
//   clr_i   : synchronous clear to zero (priority over inc_i)
//   inc_i   : increment by one unless already at all-ones
//   cnt_o   : registered count
//   max_o   : registered flag, high while the count is all-ones
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o,
    output logic         max_o
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         max_q, max_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !max_q) begin
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
        end
        // Flag tracks the next value so it rises in the same cycle the count tops out.
        max_d = &cnt_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            max_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            max_q <= max_d;
        end
    end

    assign cnt_o = cnt_q;
    assign max_o = max_q;

endmodule

// File: rtl/match_tally.sv
// match_tally
// Statistics stage behind the sequence detector: counts match pulses on ans
// (saturating), measures the spacing between consecutive matches (last and
// minimum gap) and offers a req/ack snapshot of count and last_gap that stays
// frozen while counting continues.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   ans                   : per-cycle match flag
//   clr                   : synchronous clear of the statistics (not the snapshot)
//   snap_req, snap_ack    : snapshot request / release
//   count, sat            : saturating match count and sticky saturation flag
//   last_gap, min_gap     : most recent and smallest inter-match gap
//   gap_valid             : at least one gap measured
//   snap_valid            : snapshot held
//   snap_count, snap_last_gap : frozen copies of count and last_gap
module match_tally
    import match_tally_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int GAP_W = DEF_GAP_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ans,
    input  logic             clr,
    input  logic             snap_req,
    input  logic             snap_ack,
    output logic [CNT_W-1:0] count,
    output logic             sat,
    output logic [GAP_W-1:0] last_gap,
    output logic [GAP_W-1:0] min_gap,
    output logic             gap_valid,
    output logic             snap_valid,
    output logic [CNT_W-1:0] snap_count,
    output logic [GAP_W-1:0] snap_last_gap
);

    stats_state_e st_q, st_d;
    snap_state_e  sn_q, sn_d;

    logic [CNT_W-1:0] count_w;
    logic             count_max_w;
    logic [GAP_W-1:0] gap_cnt_w;
    logic             gap_max_w;
    logic [GAP_W-1:0] gap_new_w;

    logic [GAP_W-1:0] last_gap_q, last_gap_d;
    logic [GAP_W-1:0] min_gap_q, min_gap_d;
    logic             gap_valid_q, gap_valid_d;
    logic [CNT_W-1:0] snap_count_q, snap_count_d;
    logic [GAP_W-1:0] snap_last_q, snap_last_d;

    // Match counter: clr wins over a coincident match, so the match is dropped.
    sat_counter #(.W(CNT_W)) u_count (
        .clk_i (clk),
        .rst_i (reset),
        .clr_i (clr),
        .inc_i (ans),
        .cnt_o (count_w),
        .max_o (count_max_w)
    );

    // Gap counter restarts on every match and only runs once armed.
    sat_counter #(.W(GAP_W)) u_gap (
        .clk_i (clk),
        .rst_i (reset),
        .clr_i (clr | ans),
        .inc_i ((st_q == ARMED) && !ans),
        .cnt_o (gap_cnt_w),
        .max_o (gap_max_w)
    );

    // The gap includes the match cycle itself; hold at all-ones once saturated.
    assign gap_new_w = gap_max_w ? gap_cnt_w
                                 : gap_cnt_w + {{(GAP_W-1){1'b0}}, 1'b1};

    always_comb begin
        st_d        = st_q;
        last_gap_d  = last_gap_q;
        min_gap_d   = min_gap_q;
        gap_valid_d = gap_valid_q;
        if (clr) begin
            st_d        = IDLE;
            last_gap_d  = '0;
            min_gap_d   = '1;
            gap_valid_d = 1'b0;
        end else if (ans) begin
            st_d = ARMED;
            // The first match after reset/clr only starts the gap timer.
            if (st_q == ARMED) begin
                last_gap_d  = gap_new_w;
                gap_valid_d = 1'b1;
                if (gap_new_w < min_gap_q) begin
                    min_gap_d = gap_new_w;
                end
            end
        end
    end

    // Snapshot captures the registered (pre-update, pre-clear) statistics.
    always_comb begin
        sn_d         = sn_q;
        snap_count_d = snap_count_q;
        snap_last_d  = snap_last_q;
        case (sn_q)
            S_IDLE: begin
                if (snap_req) begin
                    sn_d         = S_HOLD;
                    snap_count_d = count_w;
                    snap_last_d  = last_gap_q;
                end
            end
            S_HOLD: begin
                if (snap_ack) begin
                    sn_d = S_IDLE;
                end
            end
            default: sn_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q         <= IDLE;
            last_gap_q   <= '0;
            min_gap_q    <= '1;
            gap_valid_q  <= 1'b0;
            sn_q         <= S_IDLE;
            snap_count_q <= '0;
            snap_last_q  <= '0;
        end else begin
            st_q         <= st_d;
            last_gap_q   <= last_gap_d;
            min_gap_q    <= min_gap_d;
            gap_valid_q  <= gap_valid_d;
            sn_q         <= sn_d;
            snap_count_q <= snap_count_d;
            snap_last_q  <= snap_last_d;
        end
    end

    assign count         = count_w;
    assign sat           = count_max_w;
    assign last_gap      = last_gap_q;
    assign min_gap       = min_gap_q;
    assign gap_valid     = gap_valid_q;
    assign snap_valid    = (sn_q == S_HOLD);
    assign snap_count    = snap_count_q;
    assign snap_last_gap = snap_last_q;

endmodule
